alu_writeback: RTL
==================

Name: alu_writeback

Overview:
Writeback stage directly downstream of the ALU function units (logic, adder, shifter) in the 8-bit teaching CPU. It takes one ALU result plus flags per handshake and commits the result into an 8-entry general register file. It merges the flags into the status register under a per-flag update mask. It serves two combinational operand read ports, with same-cycle write bypass, back to the operand-fetch stage that feeds the ALU.

Parameters:
DW, 8, data width of results and registers
AW, 3, register address width; register count = 2**AW
CW, 16, width of the commit counter

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  ALU result presented this cycle
in_ready  out  1  stage can accept a result this cycle
in_sum  in  DW  ALU result
in_c  in  1  carry flag from adder (0 from logic unit)
in_s  in  1  sign flag
in_v  in  1  overflow flag
in_n  in  1  negative flag
in_z  in  1  zero flag
in_dest  in  AW  destination register index
in_wr_en  in  1  1 = write in_sum to register file
in_flag_mask  in  5  per-flag update enable, bit order {S,V,N,Z,C} = [4:0]
stall  in  1  downstream hold (e.g. memory busy); blocks commits
ra_addr  in  AW  read port A address
ra_data  out  DW  read port A data
rb_addr  in  AW  read port B address
rb_data  out  DW  read port B data
flags  out  5  status register {S,V,N,Z,C}
wb_valid  out  1  registered one-cycle pulse: a commit occurred last cycle
wb_dest  out  AW  registered destination of last commit
commit_count  out  CW  number of commits since reset

Behaviour:
- Commit condition: commit = in_valid & in_ready; in_ready = ~stall & ~reset (combinational).
- On a commit edge with in_wr_en=1: reg[in_dest] <= in_sum.
- On a commit edge with in_wr_en=0: no register write. Flags, counter and wb_* still update.
- On a commit edge, flags: for each bit i, flags[i] <= in_flag_mask[i] ? new_flag[i] : flags[i], where new_flag = {in_s,in_v,in_n,in_z,in_c}.
- No commit: register file, flags and commit_count hold. wb_valid <= 0, wb_dest holds.
- Commit: wb_valid <= 1, wb_dest <= in_dest, commit_count <= commit_count + 1.
- commit_count wraps from 2**CW-1 to 0 silently.
- Reads are combinational. ra_data = (commit & in_wr_en & in_dest==ra_addr) ? in_sum : reg[ra_addr]; rb_data uses the same rule.
- Both read ports may address the same register; both return the same value, including the bypassed value.
- No write-after-write hazard exists: one write per cycle, the later commit wins.
- in_valid asserted while stall=1: no commit, no bypass. The upstream stage holds its result until in_ready.
- Reset, in the cycle reset is sampled high: all registers <= 0, flags <= 5'b0, wb_valid <= 0, wb_dest <= 0, commit_count <= 0. in_ready is 0 throughout reset, so a result offered during reset is dropped; the upstream stage is reset in the same cycle. Bypass is suppressed during reset.
- Latency: result visible on the read ports in the same cycle via bypass, and from the array from the next cycle. flags, wb_valid and wb_dest are visible one cycle after the commit.
- X-safety: in_* values are ignored when in_valid=0.

Decomposition:
- Shared header cpu_defs.vh holds:
  - flag bit index constants FLAG_S=4, FLAG_V=3, FLAG_N=2, FLAG_Z=1, FLAG_C=0;
  - mask shorthands FLAGS_ALL=5'b11111, FLAGS_LOGIC=5'b11110, FLAGS_NONE=5'b0;
  - DW/AW defaults.
- Sub-module regfile_2r1w (synchronous write, two asynchronous reads, synchronous reset clear). alu_writeback adds the bypass muxes, status register, counter and handshake around it.

Test Plan:
- Reset then idle: assert reset 2 cycles -> flags=0, wb_valid=0, commit_count=0, ra_data=rb_data=0 for all addresses; in_ready=0 during reset, 1 after.
- Single write + bypass: in_valid=1, in_sum=8'hA5, in_dest=3, in_wr_en=1, ra_addr=3 in the same cycle -> ra_data=A5 same cycle. Next cycle: reg[3]=A5, wb_valid=1, wb_dest=3, commit_count=1.
- Flag masking: flags start at 0. Commit with {S,V,N,Z,C}=5'b11111 and mask FLAGS_LOGIC -> flags=5'b11110. Then commit flags=0 with mask 5'b00001 -> flags=5'b11110, since C is already 0 and only C updates.
- Stall: stall=1, in_valid=1, in_sum=8'h3C, dest=5 for 3 cycles -> in_ready=0, reg[5] unchanged, no bypass, commit_count unchanged. Drop stall -> commit on that edge, reg[5]=3C.
- Back-to-back commits to the same register: 8'h01 then 8'h02 to dest 7 on consecutive cycles -> reg[7]=02, commit_count +2, wb_valid high for 2 cycles. Flag-only commit (in_wr_en=0, dest=7) -> reg[7] stays 02.
- Counter wrap and reset mid-operation: preload by running 65535 commits, one more -> commit_count=0. Assert reset coincident with in_valid=1 -> no write, all state cleared next cycle.

Source files
------------

// File: rtl/alu_writeback_pkg.sv
// Shared CPU definitions for the writeback slice: flag bit positions,
// common flag-update masks, default widths and the flag merge helper.
package alu_writeback_pkg;

    // Status register bit positions, {S,V,N,Z,C} = [4:0]
    localparam int FLAG_S = 4;
    localparam int FLAG_V = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    // Flag update mask shorthands
    localparam logic [4:0] FLAGS_ALL   = 5'b11111;
    localparam logic [4:0] FLAGS_LOGIC = 5'b11110;
    localparam logic [4:0] FLAGS_NONE  = 5'b00000;

    // Default data and register-address widths
    localparam int DW_DEF = 8;
    localparam int AW_DEF = 3;

    // Take each new flag where its mask bit is set, otherwise keep the old one
    function automatic logic [4:0] merge_flags(input logic [4:0] old_flags,
                                               input logic [4:0] new_flags,
                                               input logic [4:0] mask);
        return (new_flags & mask) | (old_flags & ~mask);
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// General register file: one synchronous write port, two asynchronous
// read ports, every entry cleared by synchronous reset.
module regfile_2r1w #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] ra_addr,
    output logic [DW-1:0] ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data
);

    logic [DW-1:0] mem [2**AW];

    // Clear all entries on reset, otherwise write one entry when enabled
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign ra_data = mem[ra_addr];
    assign rb_data = mem[rb_addr];

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage behind the ALU: commits results into the register file,
// merges flags into the status register under a per-flag mask, counts
// commits and serves two operand read ports with same-cycle bypass.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_sum,
    input  logic          in_c,
    input  logic          in_s,
    input  logic          in_v,
    input  logic          in_n,
    input  logic          in_z,
    input  logic [AW-1:0] in_dest,
    input  logic          in_wr_en,
    input  logic [4:0]    in_flag_mask,
    input  logic          stall,
    input  logic [AW-1:0] ra_addr,
    output logic [DW-1:0] ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data,
    output logic [4:0]    flags,
    output logic          wb_valid,
    output logic [AW-1:0] wb_dest,
    output logic [CW-1:0] commit_count
);

    logic          commit;
    logic          rf_we;
    logic [4:0]    new_flags;
    logic [DW-1:0] ra_arr;
    logic [DW-1:0] rb_arr;

    logic [4:0]    flags_p1;
    logic          wb_valid_p1;
    logic [AW-1:0] wb_dest_p1;
    logic [CW-1:0] count_p1;

    // Reset also blocks acceptance so a result offered during reset is dropped
    assign in_ready = ~stall & ~reset;
    assign commit   = in_valid & in_ready;
    assign rf_we    = commit & in_wr_en;

    // Pack the incoming flags into status-register order
    always_comb begin
        new_flags         = '0;
        new_flags[FLAG_S] = in_s;
        new_flags[FLAG_V] = in_v;
        new_flags[FLAG_N] = in_n;
        new_flags[FLAG_Z] = in_z;
        new_flags[FLAG_C] = in_c;
    end

    regfile_2r1w #(
        .DW(DW),
        .AW(AW)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (in_dest),
        .wdata   (in_sum),
        .ra_addr (ra_addr),
        .ra_data (ra_arr),
        .rb_addr (rb_addr),
        .rb_data (rb_arr)
    );

    // A result being written this cycle is forwarded ahead of the array
    assign ra_data = (rf_we && (in_dest == ra_addr)) ? in_sum : ra_arr;
    assign rb_data = (rf_we && (in_dest == rb_addr)) ? in_sum : rb_arr;

    // Commit stage -> status register, writeback pulse and commit counter
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_p1    <= '0;
            wb_valid_p1 <= 1'b0;
            wb_dest_p1  <= '0;
            count_p1    <= '0;
        end else begin
            wb_valid_p1 <= commit;
            if (commit) begin
                flags_p1   <= merge_flags(flags_p1, new_flags, in_flag_mask);
                wb_dest_p1 <= in_dest;
                count_p1   <= count_p1 + CW'(1);
            end
        end
    end

    assign flags        = flags_p1;
    assign wb_valid     = wb_valid_p1;
    assign wb_dest      = wb_dest_p1;
    assign commit_count = count_p1;

endmodule
